// File: rtl/pc_tx_stream_pkg.sv
// Shared definitions for the PC-bound UART transmitter: FSM state encodings,
// frame lengths and the even-parity helper used by the serialiser.
package pc_tx_stream_pkg;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/pc_tx_stream_if.sv
// Word-write handshake between the DataRouter (master) and the PC transmitter (slave).
interface pc_tx_stream_if #(
    parameter int WORD_BYTES = 4
) ();
    logic [8*WORD_BYTES-1:0] wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic                    drop;

    modport master (output wr_data, output wr_valid, input wr_ready, input drop);
    modport slave  (input wr_data, input wr_valid, output wr_ready, output drop);
endinterface

// File: rtl/pc_tx_word_fifo.sv
// Word FIFO for the PC transmitter: registered storage and pointers, exact level
// counter, registered full flag, asynchronous clear.
module pc_tx_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      level_r;
    logic [AW:0]      level_n_s;
    logic             full_r;
    logic             push_s;
    logic             pop_s;

    // Full is the registered flag, so a same-cycle pop never admits a write.
    assign push_s = wr_en && !full_r;
    assign pop_s  = rd_en && (level_r != '0);

    // Next level: simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_n_s = level_r;
        if (push_s && !pop_s) begin
            level_n_s = level_r + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_n_s = level_r - LVL_ONE;
        end else begin
            level_n_s = level_r;
        end
    end

    // Storage write port.
    always_ff @(posedge i_clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level and full flag.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_n_s;
            full_r  <= (level_n_s == LVL_FULL);
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = (level_r == '0);
    assign level   = level_r;

endmodule

// File: rtl/pc_tx_stream.sv
// PC-bound UART transmitter: queues words, splits them into bytes and sends 8N1.
// Define PC_TX_PARITY_EN for 8E1 frames (even parity bit after the data bits).
module pc_tx_stream
    import pc_tx_stream_pkg::*;
#(
    parameter int WORD_BYTES   = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 435,
    parameter int MSB_FIRST    = 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    pc_tx_stream_if.slave                 wr,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_tx_active,
    output logic                          o_word_done,
    output logic                          o_uart_tx
);
    localparam int WW = 8 * WORD_BYTES;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [IW-1:0] BYTE_LAST = IW'(WORD_BYTES - 1);
    localparam logic [IW-1:0] BYTE_ONE  = IW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'd7;
    localparam logic [2:0]    BIT_ONE   = 3'd1;

    tx_state_t          state_r, state_n;
    logic [BW-1:0]      baud_r, baud_n;
    logic [2:0]         bit_idx_r, bit_idx_n;
    logic [IW-1:0]      byte_idx_r, byte_idx_n;
    logic [WW-1:0]      word_r, word_n;
    logic [7:0]         byte_r, byte_n;
    logic               tx_r, tx_n;
    logic               word_done_r, word_done_n;
    logic               active_r, active_n;
    logic               drop_r;

    logic [WW-1:0]      fifo_rd_data_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;
    logic               avail_s;
    logic               baud_end_s;

    function automatic logic [7:0] first_byte(input logic [WW-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[WW-1 -: 8];
        end else begin
            return w[7:0];
        end
    endfunction

    function automatic logic [WW-1:0] shift_word(input logic [WW-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << 4'd8;
        end else begin
            return w >> 4'd8;
        end
    endfunction

    pc_tx_word_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .wr_en   (wr.wr_valid),
        .wr_data (wr.wr_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (o_fifo_level)
    );

    // A word being written this cycle counts as available, so an idle block
    // reaches LOAD one cycle after the write and the start bit one cycle later.
    assign push_s     = wr.wr_valid && !fifo_full_s;
    assign pop_s      = (state_r == ST_LOAD);
    assign avail_s    = !fifo_empty_s || push_s;
    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state and next-bit logic; tx_n is the level of the bit being entered.
    always_comb begin
        state_n    = state_r;
        baud_n     = baud_r;
        bit_idx_n  = bit_idx_r;
        byte_idx_n = byte_idx_r;
        word_n     = word_r;
        byte_n     = byte_r;
        tx_n       = tx_r;
        case (state_r)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (avail_s) begin
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_n    = ST_START;
                tx_n       = 1'b0;
                baud_n     = '0;
                byte_idx_n = '0;
                byte_n     = first_byte(fifo_rd_data_s);
                word_n     = shift_word(fifo_rd_data_s);
            end
            ST_START: begin
                if (baud_end_s) begin
                    state_n   = ST_DATA;
                    baud_n    = '0;
                    bit_idx_n = 3'd0;
                    tx_n      = byte_r[0];
                end else begin
                    baud_n = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_n = '0;
                    if (bit_idx_r == BIT_LAST) begin
`ifdef PC_TX_PARITY_EN
                        state_n = ST_PARITY;
                        tx_n    = even_parity(byte_r);
`else
                        state_n = ST_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx_r + BIT_ONE;
                        tx_n      = byte_r[bit_idx_r + BIT_ONE];
                    end
                end else begin
                    baud_n = baud_r + BAUD_ONE;
                end
            end
            // Only reachable in 8E1 builds.
            ST_PARITY: begin
                if (baud_end_s) begin
                    state_n = ST_STOP;
                    baud_n  = '0;
                    tx_n    = 1'b1;
                end else begin
                    baud_n = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_n = '0;
                    if (byte_idx_r != BYTE_LAST) begin
                        state_n    = ST_START;
                        tx_n       = 1'b0;
                        byte_idx_n = byte_idx_r + BYTE_ONE;
                        byte_n     = first_byte(word_r);
                        word_n     = shift_word(word_r);
                    end else if (avail_s) begin
                        state_n = ST_LOAD;
                        tx_n    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_n = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
            end
        endcase
        word_done_n = (state_r == ST_STOP) && (baud_r == BAUD_PRE) && (byte_idx_r == BYTE_LAST);
        active_n    = (state_n != ST_IDLE) || avail_s;
    end

    // Serialiser state and registered status outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            baud_r      <= '0;
            bit_idx_r   <= 3'd0;
            byte_idx_r  <= '0;
            word_r      <= '0;
            byte_r      <= 8'd0;
            tx_r        <= 1'b1;
            word_done_r <= 1'b0;
            active_r    <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            baud_r      <= baud_n;
            bit_idx_r   <= bit_idx_n;
            byte_idx_r  <= byte_idx_n;
            word_r      <= word_n;
            byte_r      <= byte_n;
            tx_r        <= tx_n;
            word_done_r <= word_done_n;
            active_r    <= active_n;
            drop_r      <= wr.wr_valid && fifo_full_s;
        end
    end

    assign wr.wr_ready = !fifo_full_s;
    assign wr.drop     = drop_r;
    assign o_uart_tx   = tx_r;
    assign o_word_done = word_done_r;
    assign o_tx_active = active_r;

endmodule

// File: tb/tb_pc_tx_stream.sv
// Scoreboard bench for pc_tx_stream: two instances (MSB-first and LSB-first) share
// every write; a timing model predicts bytes, word_done, drop, level and busy.
`timescale 1ns/1ps
module tb_pc_tx_stream;
    import pc_tx_stream_pkg::*;

    localparam int WB    = 4;
    localparam int DEPTH = 4;
    localparam int CPB   = 4;
`ifdef PC_TX_PARITY_EN
    localparam int NB = FRAME_BITS_8E1;
`else
    localparam int NB = FRAME_BITS_8N1;
`endif
    localparam int WORD_CYC = WB * NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pc_tx_stream_if #(.WORD_BYTES(WB)) if_m ();
    pc_tx_stream_if #(.WORD_BYTES(WB)) if_l ();

    logic [2:0] lvl_m, lvl_l;
    logic       act_m, act_l, done_m, done_l, uart_m, uart_l;

    pc_tx_stream #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .MSB_FIRST(1)) dut_m (
        .i_clock(clk), .i_reset(rst), .wr(if_m), .o_fifo_level(lvl_m),
        .o_tx_active(act_m), .o_word_done(done_m), .o_uart_tx(uart_m));
    pc_tx_stream #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .MSB_FIRST(0)) dut_l (
        .i_clock(clk), .i_reset(rst), .wr(if_l), .o_fifo_level(lvl_l),
        .o_tx_active(act_l), .o_word_done(done_l), .o_uart_tx(uart_l));

    logic [1:0] uart_s, done_s, act_s, drop_s, ready_s;
    logic [2:0] lvl_s [2];
    assign uart_s  = {uart_l, uart_m};
    assign done_s  = {done_l, done_m};
    assign act_s   = {act_l, act_m};
    assign drop_s  = {if_l.drop, if_m.drop};
    assign ready_s = {if_l.wr_ready, if_m.wr_ready};
    assign lvl_s[0] = lvl_m;
    assign lvl_s[1] = lvl_l;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model: accepted write cycles, their LOAD cycles and expectations.
    int         wr_hist[$];
    int         ld_hist[$];
    int         last_load;
    logic [7:0] exp_byte[2][$];
    int         exp_done[2][$];
    int         exp_drop[2][$];
    int         drops_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        wr_hist.delete();
        ld_hist.delete();
        last_load = -100000;
        for (int d = 0; d < 2; d++) begin
            exp_byte[d].delete();
            exp_done[d].delete();
            exp_drop[d].delete();
        end
    endtask

    function automatic int model_level(input int c);
        int n = 0;
        for (int i = 0; i < wr_hist.size(); i++)
            if (wr_hist[i] < c && ld_hist[i] >= c) n++;
        return n;
    endfunction

    function automatic bit model_active(input int c);
        for (int i = 0; i < wr_hist.size(); i++)
            if (wr_hist[i] < c && c <= ld_hist[i] + WORD_CYC) return 1'b1;
        return 1'b0;
    endfunction

    // A word written in cycle c is loaded at max(c+1, previous load + one word + 1).
    task automatic model_write(input int c, input logic [31:0] w);
        int pending = 0;
        int ld;
        for (int i = 0; i < ld_hist.size(); i++)
            if (ld_hist[i] >= c) pending++;
        if (pending < DEPTH) begin
            ld = (c + 1 > last_load + WORD_CYC + 1) ? c + 1 : last_load + WORD_CYC + 1;
            last_load = ld;
            wr_hist.push_back(c);
            ld_hist.push_back(ld);
            for (int i = 0; i < WB; i++) begin
                exp_byte[0].push_back(w[8*(WB-1-i) +: 8]);
                exp_byte[1].push_back(w[8*i +: 8]);
            end
            for (int d = 0; d < 2; d++) exp_done[d].push_back(ld + WORD_CYC);
        end else begin
            for (int d = 0; d < 2; d++) exp_drop[d].push_back(c + 1);
        end
    endtask

    task automatic do_write(input logic [31:0] w);
        model_write(cyc, w);
        if_m.wr_data = w; if_m.wr_valid = 1'b1;
        if_l.wr_data = w; if_l.wr_valid = 1'b1;
        @(negedge clk);
        if_m.wr_valid = 1'b0;
        if_l.wr_valid = 1'b0;
    endtask

    task automatic drain();
        int lim = 0;
        while (cyc <= last_load + WORD_CYC + 3 && lim < 5000) begin
            @(negedge clk);
            lim++;
        end
        chk("drain_timeout", (lim < 5000), 1);
    endtask

    // Monitor: UART decoders, pulse scoreboards and per-cycle status checks.
    bit         dec_busy[2];
    int         dec_cnt[2];
    logic [7:0] dec_byte[2];
    initial begin
        int bn;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    dec_busy[d] = 1'b0;
                end else begin
                    if (done_s[d]) begin
                        if (exp_done[d].size() == 0) chk(d ? "unexpected_done_lsb" : "unexpected_done_msb", 1, 0);
                        else chk(d ? "done_cycle_lsb" : "done_cycle_msb", cyc, exp_done[d].pop_front());
                    end
                    if (drop_s[d]) begin
                        if (d == 0) drops_seen++;
                        if (exp_drop[d].size() == 0) chk(d ? "unexpected_drop_lsb" : "unexpected_drop_msb", 1, 0);
                        else chk(d ? "drop_cycle_lsb" : "drop_cycle_msb", cyc, exp_drop[d].pop_front());
                    end
                    if (!dec_busy[d]) begin
                        if (uart_s[d] == 1'b0) begin
                            dec_busy[d] = 1'b1;
                            dec_cnt[d]  = 0;
                        end
                    end else begin
                        dec_cnt[d]++;
                        if (dec_cnt[d] >= CPB/2 && (dec_cnt[d] - CPB/2) % CPB == 0) begin
                            bn = (dec_cnt[d] - CPB/2) / CPB;
                            if (bn == NB - 1) begin
                                chk(d ? "stop_bit_lsb" : "stop_bit_msb", uart_s[d], 1);
                                if (exp_byte[d].size() == 0) chk(d ? "unexpected_byte_lsb" : "unexpected_byte_msb", dec_byte[d], 0);
                                else chk(d ? "byte_lsb" : "byte_msb", dec_byte[d], exp_byte[d].pop_front());
                                dec_busy[d] = 1'b0;
                            end else if (bn == 9) begin
                                chk(d ? "parity_lsb" : "parity_msb", uart_s[d], ^dec_byte[d]);
                            end else if (bn >= 1) begin
                                dec_byte[d][bn-1] = uart_s[d];
                            end
                        end
                    end
                    if (chk_en) begin
                        chk(d ? "level_lsb" : "level_msb", lvl_s[d], model_level(cyc));
                        chk(d ? "active_lsb" : "active_msb", act_s[d], model_active(cyc));
                        chk(d ? "ready_lsb" : "ready_msb", ready_s[d], (model_level(cyc) < DEPTH));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, t, d_cyc, lows;
        if_m.wr_valid = 1'b0; if_m.wr_data = '0;
        if_l.wr_valid = 1'b0; if_l.wr_data = '0;
        clear_model();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_uart", uart_s[d], 1);
            chk("rst_ready", ready_s[d], 1);
            chk("rst_level", lvl_s[d], 0);
            chk("rst_active", act_s[d], 0);
            chk("rst_drop", drop_s[d], 0);
            chk("rst_done", done_s[d], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        // Single word: start edge at N+2, word_done at N+161, then idle.
        c0 = cyc;
        do_write(32'h5448_4953);
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            if (uart_s[0] == 1'b0) t = cyc;
            else @(negedge clk);
        end
        chk("start_edge_cycle", t, c0 + 2);
        t = -1;
        for (int i = 0; i < 400 && t < 0; i++) begin
            if (done_s[0]) t = cyc;
            else @(negedge clk);
        end
        chk("word_done_cycle", t, c0 + 2 + 159);
        @(negedge clk);
        chk("active_after_word", act_s[0], 0);
        drain();

        // Overflow: one word in flight, five more back to back, fifth dropped.
        c0 = cyc;
        do_write(32'hA1A2_A3A4);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) do_write($urandom);
        chk("level_full", lvl_s[0], 4);
        chk("ready_full", ready_s[0], 0);
        @(negedge clk);
        chk("drop_count", drops_seen, 1);
        drain();

        // Two queued words: exactly one idle cycle between them.
        do_write(32'h0102_0304);
        do_write(32'hF0E1_D2C3);
        t = -1;
        for (int i = 0; i < 400 && t < 0; i++) begin
            if (done_s[1]) t = cyc;
            else @(negedge clk);
        end
        d_cyc = t;
        @(negedge clk);
        chk("gap_idle_high", uart_s[1], 1);
        @(negedge clk);
        chk("gap_next_start", uart_s[1], 0);
        chk("gap_next_start_cycle", cyc, d_cyc + 2);
        drain();

        // Reset in a data bit (bit 1, value 0) of byte 2 with two words queued.
        c0 = cyc;
        do_write(32'h5448_4953);
        do_write($urandom);
        do_write($urandom);
        repeat (c0 + 91 - cyc) @(negedge clk);
        chk("pre_reset_bit_msb", uart_s[0], 0);
        chk("pre_reset_bit_lsb", uart_s[1], 0);
        chk("pre_reset_level", lvl_s[0], 2);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_line_msb", uart_s[0], 1);
        chk("reset_line_lsb", uart_s[1], 1);
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            if (uart_s != 2'b11) lows++;
            @(negedge clk);
        end
        chk("idle_after_reset", lows, 0);
        chk("level_after_reset", lvl_s[0], 0);

        // Randomised traffic with bursts that overflow the FIFO.
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 180)) @(negedge clk);
            do_write($urandom);
        end
        drain();
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("bytes_left", exp_byte[d].size(), 0);
            chk("done_left", exp_done[d].size(), 0);
            chk("drop_left", exp_drop[d].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
